axis_fifo_reader: RTL and testbench
===================================

AXIS_FIFO_READER -- requirements
Module: axis_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: FIFO word and TDATA width.
REQ-002 SHALL have parameter BURST_LEN, default 16: beats per packet; TLAST is asserted on the final beat; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: permits new FIFO pops while high.
REQ-006 SHALL have port fifo_empty, input, 1 bit: empty flag from the upstream FIFO.
REQ-007 SHALL have port fifo_pop, output, 1 bit: single-cycle pop request to the upstream FIFO.
REQ-008 SHALL have port fifo_data, input, DATA_WIDTH bits: FIFO read word, valid exactly one cycle after an accepted pop.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: AXI-Stream master valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: AXI-Stream slave ready.
REQ-011 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: stream data.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: packet end marker.
REQ-013 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN and DRAIN.
REQ-015 SHALL move IDLE->RUN when enable=1 and fifo_empty=0.
REQ-016 SHALL move RUN->DRAIN when enable falls.
REQ-017 SHALL move DRAIN->IDLE when the buffer is empty and no pop is in flight.
REQ-018 SHALL move DRAIN->RUN when enable rises again before the buffer empties.
REQ-019 SHALL hold 2-entry output buffer (skid) plus 1-bit in-flight flag; outstanding = entries + inflight.
REQ-020 SHALL assert fifo_pop combinationally iff state=RUN, fifo_empty=0, and either outstanding<2 or (outstanding=2 and tvalid and tready).
REQ-021 SHALL never assert fifo_pop when fifo_empty=1, in IDLE, or in DRAIN.
REQ-022 SHALL capture fifo_data into the buffer tail the cycle after a pop; the in-flight flag clears the same edge.
REQ-023 SHALL drive tvalid=1 whenever entries>=1, with tdata taken from the buffer head.
REQ-024 SHALL pop the buffer head on tvalid and tready.
REQ-025 SHALL hold tdata and tlast stable while tvalid=1 and tready=0 (AXI-Stream rule).
REQ-026 SHALL sustain 1 beat/cycle with tready held high; first tvalid appears 2 cycles after the first pop.
REQ-027 SHALL count accepted beats in a ceil(log2(BURST_LEN+1))-bit counter.
REQ-028 SHALL assert tlast when the counter equals BURST_LEN-1.
REQ-029 SHALL wrap the counter to 0 on the tlast handshake; for BURST_LEN=1, tlast SHALL be high on every beat.
REQ-030 SHALL carry the counter unchanged across DRAIN/IDLE, so packets span enable gaps.
REQ-031 SHALL apply push and pop together in one cycle, leaving the entry count unchanged and preserving order.
REQ-032 SHALL tolerate fifo_empty rising while a pop is in flight; the in-flight word is still captured.

Reset
REQ-033 SHALL on reset_n low set state=IDLE, entries=0, inflight=0, beat counter=0, and buffer data to 0.
REQ-034 SHALL hold fifo_pop=0, tvalid=0, tlast=0, tdata=0 and busy=0 during reset.
REQ-035 SHALL discard buffered and in-flight data when reset is asserted mid-transfer; no beat is emitted after reset release until a new pop completes.

Structure
REQ-036 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and the clogb2 width function in shared package axis_pkg.
REQ-037 SHALL implement the 2-entry buffer as sub-module axis_skid_buffer (push/data_in/pop, head data, count); FSM, pop logic and beat counter SHALL sit in the top.

Verification
REQ-038 Bench SHALL check: FIFO preloaded with 0x1..0x10, BURST_LEN=16, tready=1, enable=1 -> 16 consecutive beats 0x1..0x10, tlast only on 0x10, fifo_pop high for 16 cycles.
REQ-039 Bench SHALL check: tready toggling 1,0,1,0 during the stream -> no data lost or duplicated, tdata stable whenever tvalid=1 and tready=0, at most 2 beats buffered.
REQ-040 Bench SHALL check: enable dropped after 5 pops -> DRAIN, remaining buffered beats delivered, then IDLE with busy=0; re-enable -> beat 6 carries counter value 5.
REQ-041 Bench SHALL check: fifo_empty asserted the cycle after a pop -> that word is still delivered and no further fifo_pop is issued.
REQ-042 Bench SHALL check: BURST_LEN=1 with 3 words -> tlast=1 on all 3 beats.
REQ-043 Bench SHALL check: reset_n pulsed low with 2 words buffered and tready=0 -> tvalid=0 immediately, and neither word appears after release.

Source files
------------

// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream FIFO reader slice.
//   ST_IDLE / ST_RUN / ST_DRAIN : reader FSM state encoding
//   SKID_DEPTH                  : number of entries in the output skid buffer
//   clogb2(value)               : ceil(log2(value)), minimum width to hold
//                                 values 0..value-1
// ---------------------------------------------------------------------------
package axis_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int SKID_DEPTH = 2;

  // Elaboration-time helper; a bounded loop keeps it synthesizable.
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry in-order buffer that sits between the FIFO read port and the
// AXI-Stream output. Push and pop may happen in the same cycle.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   push, data_in  : write data_in at the tail
//   pop            : remove the head entry (ignored when empty)
//   head_data      : oldest entry (0 after reset)
//   count          : number of valid entries, 0..2
// ---------------------------------------------------------------------------
module axis_skid_buffer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            count_q;
  logic                  pop_eff;

  assign pop_eff   = pop && (count_q != 2'd0);
  assign head_data = head_q;
  assign count     = count_q;

  // Entry 0 is always the head; a pop shifts the tail forward so the
  // output mux stays a plain register read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (push && pop_eff) begin
      if (count_q == 2'd1) begin
        head_q <= data_in;
      end else begin
        head_q <= tail_q;
        tail_q <= data_in;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_q  <= data_in;
        count_q <= 2'd1;
      end else if (count_q == 2'd1) begin
        tail_q  <= data_in;
        count_q <= FULL;
      end
    end else if (pop_eff) begin
      head_q  <= tail_q;
      count_q <= count_q - 2'd1;
    end
  end

endmodule

// File: rtl/axis_fifo_reader.sv
// ---------------------------------------------------------------------------
// axis_fifo_reader
// Pops words from a one-cycle-latency upstream FIFO and streams them out as
// AXI-Stream packets of BURST_LEN beats.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   enable                      : permits new FIFO pops while high
//   fifo_empty, fifo_pop        : upstream FIFO handshake
//   fifo_data                   : FIFO word, valid the cycle after a pop
//   m_axis_tvalid/tready/tdata/tlast : AXI-Stream master
//   busy                        : FSM is not idle
// ---------------------------------------------------------------------------
module axis_fifo_reader
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  localparam int              CNT_W     = clogb2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  inflight_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [1:0]            outstanding;
  logic                  handshake;

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (inflight_q),
    .data_in  (fifo_data),
    .pop      (handshake),
    .head_data(buf_head),
    .count    (buf_count)
  );

  assign m_axis_tvalid = (buf_count != 2'd0);
  assign m_axis_tdata  = buf_head;
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt_q == LAST_BEAT);
  assign busy          = (state_q != ST_IDLE);

  // A word in flight will land in the buffer next edge, so it counts
  // against the two slots. At exactly two, a pop is only safe when the
  // head leaves in the same cycle.
  assign outstanding = buf_count + {1'b0, inflight_q};
  assign fifo_pop    = (state_q == ST_RUN) && enable && !fifo_empty &&
                       ((outstanding < 2'd2) ||
                        ((outstanding == 2'd2) && handshake));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if ((buf_count == 2'd0) && !inflight_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The beat counter is never cleared by the FSM, so a packet can span
  // an enable gap and resume where it stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_pop;
      if (handshake) begin
        if (m_axis_tlast) begin
          beat_cnt_q <= '0;
        end else begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo_reader
// Directed bench for axis_fifo_reader: one instance with BURST_LEN=16 and one
// with BURST_LEN=1, each fed by a small one-cycle-latency FIFO model.
// ---------------------------------------------------------------------------
module tb_axis_fifo_reader;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        enable2;
  logic        tready;
  logic        force_empty1;

  logic        fifo_empty1, fifo_pop1;
  logic [31:0] fifo_data1, tdata1;
  logic        tvalid1, tlast1, busy1;

  logic        fifo_empty2, fifo_pop2;
  logic [31:0] fifo_data2, tdata2;
  logic        tvalid2, tlast2, busy2;

  int tests_run;
  int tests_failed;

  logic [31:0] fmem1 [0:63];
  logic [31:0] fmem2 [0:63];
  int          wr1, rd1, wr2, rd2;

  logic [31:0] beat_data1 [$];
  logic        beat_last1 [$];
  int          beat_cyc1  [$];
  int          pop_cyc1   [$];
  logic [31:0] beat_data2 [$];
  logic        beat_last2 [$];

  int          cyc;
  int          outst;
  logic        stall_prev;
  logic [31:0] prev_data;
  logic        prev_last;

  axis_fifo_reader #(.DATA_WIDTH(32), .BURST_LEN(16)) u_dut16 (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty1),
    .fifo_pop     (fifo_pop1),
    .fifo_data    (fifo_data1),
    .m_axis_tvalid(tvalid1),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata1),
    .m_axis_tlast (tlast1),
    .busy         (busy1)
  );

  axis_fifo_reader #(.DATA_WIDTH(32), .BURST_LEN(1)) u_dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable2),
    .fifo_empty   (fifo_empty2),
    .fifo_pop     (fifo_pop2),
    .fifo_data    (fifo_data2),
    .m_axis_tvalid(tvalid2),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata2),
    .m_axis_tlast (tlast2),
    .busy         (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty1 = force_empty1 || (rd1 == wr1);
  assign fifo_empty2 = (rd2 == wr2);

  // Upstream FIFO models: data is valid only the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_pop1 && !fifo_empty1) begin
      fifo_data1 <= fmem1[rd1];
      rd1        <= rd1 + 1;
    end else begin
      fifo_data1 <= 32'hDEAD_BEEF;
    end
    if (fifo_pop2 && !fifo_empty2) begin
      fifo_data2 <= fmem2[rd2];
      rd2        <= rd2 + 1;
    end else begin
      fifo_data2 <= 32'hDEAD_BEEF;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Stream monitor: logs pops and beats, checks AXI hold rule and occupancy.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      stall_prev = 1'b0;
      outst      = 0;
    end else begin
      if (stall_prev) begin
        checkOutput("hold_valid", 64'(tvalid1), 64'd1);
        checkOutput("hold_data", 64'(tdata1), 64'(prev_data));
        checkOutput("hold_last", 64'(tlast1), 64'(prev_last));
      end
      checkOutput("occupancy", 64'(outst <= 2), 64'd1);
      stall_prev = tvalid1 && !tready;
      prev_data  = tdata1;
      prev_last  = tlast1;
      if (fifo_pop1) begin
        pop_cyc1.push_back(cyc);
        outst++;
      end
      if (tvalid1 && tready) begin
        beat_data1.push_back(tdata1);
        beat_last1.push_back(tlast1);
        beat_cyc1.push_back(cyc);
        outst--;
      end
      if (tvalid2 && tready) begin
        beat_data2.push_back(tdata2);
        beat_last2.push_back(tlast2);
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic rdy);
    @(posedge clk);
    #1;
    enable = en;
    tready = rdy;
  endtask

  task automatic loadFifo1(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      fmem1[wr1 % 64] = base + 32'(i);
      wr1++;
    end
  endtask

  task automatic waitBeats1(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while ((beat_data1.size() < target) && (i < budget)) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput({tag, "_beats"}, 64'(beat_data1.size()), 64'(target));
  endtask

  task automatic waitIdle1(input int budget, input string tag);
    int i;
    i = 0;
    while (busy1 && (i < budget)) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput({tag, "_idle"}, 64'(busy1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0, p0, n, guard;
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    outst = 0;
    stall_prev = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    wr1 = 0; rd1 = 0; wr2 = 0; rd2 = 0;
    reset_n = 1'b0;
    enable = 1'b1;
    enable2 = 1'b0;
    tready = 1'b1;
    force_empty1 = 1'b0;
    loadFifo1(16, 32'h1);

    // Reset state: FIFO non-empty and enable high, yet everything idle.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pop", 64'(fifo_pop1), 64'd0);
    checkOutput("rst_tvalid", 64'(tvalid1), 64'd0);
    checkOutput("rst_tlast", 64'(tlast1), 64'd0);
    checkOutput("rst_tdata", 64'(tdata1), 64'd0);
    checkOutput("rst_busy", 64'(busy1), 64'd0);
    checkOutput("rst_tlast_b1", 64'(tlast2), 64'd0);

    // Full packet at one beat per cycle.
    b0 = beat_data1.size();
    p0 = pop_cyc1.size();
    reset_n = 1'b1;
    waitBeats1(b0 + 16, 80, "t2");
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t2_data%0d", i), 64'(beat_data1[b0 + i]), 64'(i + 1));
      checkOutput($sformatf("t2_last%0d", i), 64'(beat_last1[b0 + i]), 64'(i == 15));
    end
    checkOutput("t2_pops", 64'(pop_cyc1.size() - p0), 64'd16);
    checkOutput("t2_pop_run", 64'(pop_cyc1[p0 + 15] - pop_cyc1[p0]), 64'd15);
    checkOutput("t2_beat_run", 64'(beat_cyc1[b0 + 15] - beat_cyc1[b0]), 64'd15);
    checkOutput("t2_latency", 64'(beat_cyc1[b0] - pop_cyc1[p0]), 64'd2);
    applyStimulus(1'b0, 1'b1);
    waitIdle1(20, "t2");

    // Backpressure: tready toggles 1,0,1,0.
    loadFifo1(16, 32'h21);
    b0 = beat_data1.size();
    p0 = pop_cyc1.size();
    for (int i = 0; (i < 150) && (beat_data1.size() < b0 + 16); i++) begin
      applyStimulus(1'b1, (i % 2) == 0);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3_beats", 64'(beat_data1.size() - b0), 64'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t3_data%0d", i), 64'(beat_data1[b0 + i]), 64'(32'h21 + 32'(i)));
      checkOutput($sformatf("t3_last%0d", i), 64'(beat_last1[b0 + i]), 64'(i == 15));
    end
    checkOutput("t3_pops", 64'(pop_cyc1.size() - p0), 64'd16);
    applyStimulus(1'b0, 1'b1);
    waitIdle1(20, "t3");

    // Enable dropped after five pops, packet resumes on re-enable.
    loadFifo1(16, 32'h41);
    b0 = beat_data1.size();
    p0 = pop_cyc1.size();
    applyStimulus(1'b1, 1'b1);
    n = 0;
    guard = 0;
    while ((n < 5) && (guard < 50)) begin
      @(posedge clk);
      #1;
      if (fifo_pop1) n++;
      guard++;
    end
    applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("t4_drain_busy", 64'(busy1), 64'd1);
    waitIdle1(20, "t4");
    checkOutput("t4_pops", 64'(pop_cyc1.size() - p0), 64'd5);
    checkOutput("t4_drained", 64'(beat_data1.size() - b0), 64'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4_data%0d", i), 64'(beat_data1[b0 + i]), 64'(32'h41 + 32'(i)));
      checkOutput($sformatf("t4_last%0d", i), 64'(beat_last1[b0 + i]), 64'd0);
    end
    applyStimulus(1'b1, 1'b1);
    waitBeats1(b0 + 16, 80, "t4");
    for (int i = 5; i < 16; i++) begin
      checkOutput($sformatf("t4_data%0d", i), 64'(beat_data1[b0 + i]), 64'(32'h41 + 32'(i)));
      checkOutput($sformatf("t4_last%0d", i), 64'(beat_last1[b0 + i]), 64'(i == 15));
    end
    applyStimulus(1'b0, 1'b1);
    waitIdle1(20, "t4b");

    // fifo_empty rises while the first pop is in flight.
    loadFifo1(3, 32'h61);
    b0 = beat_data1.size();
    p0 = pop_cyc1.size();
    applyStimulus(1'b1, 1'b1);
    guard = 0;
    while (!fifo_pop1 && (guard < 20)) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    force_empty1 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t5_pops", 64'(pop_cyc1.size() - p0), 64'd1);
    checkOutput("t5_beats", 64'(beat_data1.size() - b0), 64'd1);
    checkOutput("t5_data", 64'(beat_data1[b0]), 64'h61);
    applyStimulus(1'b0, 1'b1);
    waitIdle1(20, "t5");

    // BURST_LEN=1: every beat is a packet end.
    for (int i = 0; i < 3; i++) begin
      fmem2[wr2] = 32'h81 + 32'(i);
      wr2++;
    end
    @(posedge clk);
    #1;
    enable2 = 1'b1;
    guard = 0;
    while ((beat_data2.size() < 3) && (guard < 40)) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("t6_beats", 64'(beat_data2.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6_data%0d", i), 64'(beat_data2[i]), 64'(32'h81 + 32'(i)));
      checkOutput($sformatf("t6_last%0d", i), 64'(beat_last2[i]), 64'd1);
    end
    enable2 = 1'b0;

    // Reset with two words stalled in the buffer.
    p0 = pop_cyc1.size();
    applyStimulus(1'b1, 1'b0);
    force_empty1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t7_pops", 64'(pop_cyc1.size() - p0), 64'd2);
    checkOutput("t7_stall_valid", 64'(tvalid1), 64'd1);
    checkOutput("t7_stall_data", 64'(tdata1), 64'h62);
    loadFifo1(2, 32'h71);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t7_full_nopop", 64'(pop_cyc1.size() - p0), 64'd2);
    b0 = beat_data1.size();
    reset_n = 1'b0;
    #1;
    checkOutput("t7_rst_tvalid", 64'(tvalid1), 64'd0);
    checkOutput("t7_rst_tdata", 64'(tdata1), 64'd0);
    checkOutput("t7_rst_pop", 64'(fifo_pop1), 64'd0);
    checkOutput("t7_rst_busy", 64'(busy1), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1);
    waitBeats1(b0 + 2, 40, "t7");
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t7_no_stale", 64'(beat_data1.size() - b0), 64'd2);
    checkOutput("t7_data0", 64'(beat_data1[b0]), 64'h71);
    checkOutput("t7_data1", 64'(beat_data1[b0 + 1]), 64'h72);
    checkOutput("t7_last0", 64'(beat_last1[b0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
